// File: rtl/vi_frame_capture.sv
`default_nettype none
// vi_frame_capture: gathers Va..Ic from the solution stream into a shadow bank and
// commits complete frames to the power stage with a sta/busy/done handshake.
module vi_frame_capture #(
   parameter int                WIDTH   = 32,
   parameter int                ADDR_W  = 8,
   parameter logic [ADDR_W-1:0] ADDR_VA = 8'h10,
   parameter logic [ADDR_W-1:0] ADDR_VB = 8'h11,
   parameter logic [ADDR_W-1:0] ADDR_VC = 8'h12,
   parameter logic [ADDR_W-1:0] ADDR_IA = 8'h20,
   parameter logic [ADDR_W-1:0] ADDR_IB = 8'h21,
   parameter logic [ADDR_W-1:0] ADDR_IC = 8'h22,
   parameter int                TIMEOUT = 64,
   parameter int                CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rst_user,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              frame_end,
   input  logic              done_sig,
   output logic [WIDTH-1:0]  Va,
   output logic [WIDTH-1:0]  Vb,
   output logic [WIDTH-1:0]  Vc,
   output logic [WIDTH-1:0]  Ia,
   output logic [WIDTH-1:0]  Ib,
   output logic [WIDTH-1:0]  Ic,
   output logic              sta,
   output logic              busy,
   output logic [CNT_W-1:0]  overrun_cnt,
   output logic [CNT_W-1:0]  missing_cnt,
   output logic              timeout_flag
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam int              TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t           r_state;
   logic [TO_W-1:0]  r_to_cnt;
   logic [5:0]       r_mask;
   logic [WIDTH-1:0] r_shadow [6];
   logic [WIDTH-1:0] r_out    [6];
   logic             r_sta;
   logic             r_busy;
   logic             r_timeout;
   logic [CNT_W-1:0] r_overrun;
   logic [CNT_W-1:0] r_missing;

   logic [5:0]       w_sel;
   logic [5:0]       w_mask_nx;
   logic [WIDTH-1:0] w_shadow_nx [6];
   logic             w_expired;
   logic             w_release;
   logic             w_free;
   logic             w_accept;
   logic             w_missing;
   logic             w_overrun;

   // Bit order of the mask and bank: Va, Vb, Vc, Ia, Ib, Ic from bit 0 upward.
   assign w_sel = {6{wr_en}} & {wr_addr == ADDR_IC, wr_addr == ADDR_IB, wr_addr == ADDR_IA,
                                wr_addr == ADDR_VC, wr_addr == ADDR_VB, wr_addr == ADDR_VA};

   always_comb begin
      for (int i = 0; i < 6; i++) begin
         w_shadow_nx[i] = w_sel[i] ? wr_data : r_shadow[i];
      end
   end

   assign w_mask_nx = r_mask | w_sel;
   assign w_expired = (r_state == S_WAIT) && !done_sig && (r_to_cnt == TO_LAST);
   assign w_release = (r_state == S_WAIT) && (done_sig || (r_to_cnt == TO_LAST));
   // A release frees the block in the same cycle, so a coincident frame_end is evaluated.
   assign w_free    = (r_state == S_IDLE) || w_release;
   assign w_accept  = frame_end && w_free && (&w_mask_nx);
   assign w_missing = frame_end && w_free && !(&w_mask_nx);
   assign w_overrun = frame_end && !w_free;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_to_cnt  <= '0;
         r_mask    <= '0;
         r_sta     <= 1'b0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_overrun <= '0;
         r_missing <= '0;
         for (int i = 0; i < 6; i++) begin
            r_shadow[i] <= '0;
            r_out[i]    <= '0;
         end
      end else if (rst_user) begin
         r_state   <= S_IDLE;
         r_to_cnt  <= '0;
         r_mask    <= '0;
         r_sta     <= 1'b0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_overrun <= '0;
         r_missing <= '0;
         for (int i = 0; i < 6; i++) begin
            r_shadow[i] <= '0;
            r_out[i]    <= '0;
         end
      end else begin
         r_sta <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_shadow[i] <= w_shadow_nx[i];
         end
         r_mask <= frame_end ? 6'b0 : w_mask_nx;

         case (r_state)
            S_IDLE: begin
               r_state <= S_IDLE;
            end
            S_ISSUE: begin
               r_state  <= S_WAIT;
               r_to_cnt <= '0;
            end
            S_WAIT: begin
               if (w_release) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                  if (w_expired) begin
                     r_timeout <= 1'b1;
                  end
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Acceptance overrides the release assignments above.
         if (w_accept) begin
            for (int i = 0; i < 6; i++) begin
               r_out[i] <= w_shadow_nx[i];
            end
            r_sta   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
         end
         if (w_missing && (r_missing != '1)) begin
            r_missing <= r_missing + 1'b1;
         end
         if (w_overrun && (r_overrun != '1)) begin
            r_overrun <= r_overrun + 1'b1;
         end
      end
   end

   assign Va           = r_out[0];
   assign Vb           = r_out[1];
   assign Vc           = r_out[2];
   assign Ia           = r_out[3];
   assign Ib           = r_out[4];
   assign Ic           = r_out[5];
   assign sta          = r_sta;
   assign busy         = r_busy;
   assign overrun_cnt  = r_overrun;
   assign missing_cnt  = r_missing;
   assign timeout_flag = r_timeout;

endmodule
`default_nettype wire

// File: doc/vi_frame_capture.md
Name: vi_frame_capture

Overview:
- Upstream feeder for the three-phase active-power calculation stage.
- The network-solution engine streams node results one word per cycle (address + single-precision word).
- This block captures the six phase quantities Va, Vb, Vc, Ia, Ib, Ic into a shadow bank. At each frame end it commits a complete frame to stable output registers, then issues a one-cycle sta pulse.
- It tracks the power stage's busy window via done_sig and reports dropped, incomplete and hung frames.

Parameters:
- WIDTH, 32, data word width (IEEE-754 single).
- ADDR_W, 8, write-address width.
- ADDR_VA, 8'h10, stream address of Va.
- ADDR_VB, 8'h11, stream address of Vb.
- ADDR_VC, 8'h12, stream address of Vc.
- ADDR_IA, 8'h20, stream address of Ia.
- ADDR_IB, 8'h21, stream address of Ib.
- ADDR_IC, 8'h22, stream address of Ic.
- TIMEOUT, 64, max cycles in WAIT_DONE before forced release.
- CNT_W, 8, width of the saturating event counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rst_user  in  1  synchronous active-high user clear; same effect as rst, applied at the clock edge.
- wr_en  in  1  stream word valid.
- wr_addr  in  ADDR_W  stream word address.
- wr_data  in  WIDTH  stream word.
- frame_end  in  1  one-cycle pulse marking the end of a solution step.
- done_sig  in  1  one-cycle completion pulse from the power stage.
- Va, Vb, Vc, Ia, Ib, Ic  out  WIDTH each  committed frame values.
- sta  out  1  one-cycle start pulse to the power stage.
- busy  out  1  high from the sta cycle until release.
- overrun_cnt  out  CNT_W  frames dropped because downstream was busy (saturating).
- missing_cnt  out  CNT_W  frames dropped because capture was incomplete (saturating).
- timeout_flag  out  1  sticky; set on forced release.

Behaviour:
Reset values (rst low, or rst_user high at an edge):
- All outputs 0, shadow bank 0, capture mask 0, state IDLE, timeout counter 0.

Capture:
- wr_en=1 with wr_addr equal to one of the six address parameters loads wr_data into that shadow register and sets its mask bit.
- A repeated write to the same address within a frame: last write wins.
- Non-matching addresses are ignored.

Frame evaluation:
- Evaluated on a frame_end cycle.
- A matching write in that same cycle is included in the evaluation; mask-complete is computed including that write.

State machine:
- IDLE:
  - frame_end with mask complete: at the next edge, copy shadow to the outputs, clear the mask, set sta=1, busy=1, go to ISSUE.
  - frame_end with mask incomplete: missing_cnt+1, clear mask, outputs unchanged, stay in IDLE.
- ISSUE (exactly one cycle): sta=1. Next edge: sta=0, go to WAIT_DONE, timeout counter=0.
- WAIT_DONE:
  - done_sig=1: busy=0, go to IDLE.
  - Otherwise the timeout counter increments. On reaching TIMEOUT-1 without done_sig: timeout_flag=1, busy=0, go to IDLE.

Latency and output stability:
- frame_end in cycle N gives updated outputs and sta=1 in cycle N+1. Outputs then hold stable until the next accepted frame; the power stage samples them over multiple cycles.

Frame drop while busy:
- frame_end in ISSUE or WAIT_DONE with no done_sig the same cycle: overrun_cnt+1, mask cleared, outputs and state unchanged, no sta.

Simultaneous events:
- done_sig and frame_end in the same WAIT_DONE cycle: release takes priority. The frame is evaluated as in IDLE and, if complete, accepted. Next state ISSUE, sta in N+1.
- done_sig in IDLE or ISSUE: ignored.
- A frame_end that lands on the timeout cycle is treated like done_sig (release first).

Other rules:
- Counters saturate at all-ones and never wrap.
- Writes keep filling the shadow bank in every state. The shadow bank never disturbs the output registers except at commit.
- Reset mid-frame or mid-WAIT_DONE: immediate return to reset values; any pending sta is cancelled.

Test Plan:
1. Write Va=3F800000, Vb=40000000, Vc=40400000, Ia=40800000, Ib=40A00000, Ic=40C00000, then frame_end at cycle N -> outputs equal those words at N+1, sta high only in N+1, busy=1; done_sig at N+20 -> busy=0 at N+21.
2. Write only five quantities (omit Ic), then frame_end -> no sta, outputs unchanged, missing_cnt=1, mask cleared (a next frame with only Ic is also incomplete, missing_cnt=2).
3. Accepted frame, then a second complete frame_end at N+10 with no done_sig -> overrun_cnt=1, outputs still hold frame-1 values, no second sta.
4. done_sig and frame_end (complete frame) in the same cycle -> sta the next cycle with the new values, overrun_cnt unchanged.
5. Accepted frame, done_sig withheld for 70 cycles with TIMEOUT=64 -> busy drops 64 cycles after entering WAIT_DONE, timeout_flag=1 and sticky; the next complete frame is accepted.
6. Pull rst low during WAIT_DONE, and separately pulse rst_user during ISSUE -> all outputs 0, state IDLE, counters 0; saturation check: 300 incomplete frames with CNT_W=8 -> missing_cnt=255.
